// File: rtl/gray_decoder_chk.sv
// rtl/gray_decoder_chk.sv - Gray-to-binary decoder with step-legality checker and lock FSM
//
// Converts a reflected-binary Gray sample to binary. Each accepted sample is
// classified against the previous one as UP, DOWN, HOLD or BAD, with
// wrap-around allowed. A small FSM (IDLE -> ACQ -> LOCK) tracks whether the
// stream is following legal steps.
//
// Parameters:
//   WIDTH      code width in bits (2..16)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies g for one cycle
//   g          Gray code sample
//   out_valid  qualifies b, dir_up and step_err (one cycle after in_valid)
//   b          registered binary value of the last accepted sample
//   dir_up     1 if the last good step was +1, 0 if it was -1
//   step_err   one-cycle pulse with out_valid on an illegal step
//   locked     high while the FSM is in LOCK, one cycle behind the state
//   err_cnt    saturating count of illegal steps
// Build options:
//   GRAY_ERR_CNT_EN  when defined, err_cnt is a saturating counter;
//                    otherwise err_cnt is tied to zero
module gray_decoder_chk #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] g,
   output logic             out_valid,
   output logic [WIDTH-1:0] b,
   output logic             dir_up,
   output logic             step_err,
   output logic             locked,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] g_bin;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] diff;
   logic             is_up;
   logic             is_down;
   logic             is_bad;
   logic             err_nxt;
   logic             dir_nxt;

   // Each binary bit is the XOR of all Gray bits at or above its position.
   always_comb begin
      g_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         g_bin[i] = ^(g >> i);
      end
   end

   // Modular difference makes the wrap from all-ones to zero a +1 step.
   assign diff    = g_bin - prev;
   assign is_up   = (diff == WIDTH'(1));
   assign is_down = (diff == '1);
   assign is_bad  = !(is_up || is_down || (diff == '0));

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      dir_nxt   = dir_up;
      if (in_valid) begin
         case (state)
            IDLE: begin
               // No reference yet: just acquire the position.
               state_nxt = ACQ;
            end
            ACQ: begin
               if (is_up || is_down) begin
                  state_nxt = LOCK;
               end else if (is_bad) begin
                  err_nxt = 1'b1;
               end
            end
            LOCK: begin
               if (is_bad) begin
                  state_nxt = ACQ;
                  err_nxt   = 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
         if (state != IDLE) begin
            if (is_up) begin
               dir_nxt = 1'b1;
            end else if (is_down) begin
               dir_nxt = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         b         <= '0;
         prev      <= '0;
         dir_up    <= 1'b0;
         step_err  <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= in_valid;
         step_err  <= err_nxt;
         dir_up    <= dir_nxt;
         // locked reflects the state the sample was judged in, so it
         // drops the cycle after the step_err pulse that left LOCK.
         locked    <= (state == LOCK);
         // Bad samples load too, so tracking resynchronises.
         if (in_valid) begin
            b    <= g_bin;
            prev <= g_bin;
         end
      end
   end

`ifdef GRAY_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 8'd0;
      end else if (err_nxt && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: doc/gray_decoder_chk.md
GRAY_DECODER_CHK -- requirements
Module: gray_decoder_chk

Interface
- REQ-001 The module SHALL have parameter WIDTH, default 4, giving the code width in bits (legal range 2..16).
- REQ-002 The module SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
- REQ-003 The module SHALL have input rst_n, 1 bit, an asynchronous active-low reset.
- REQ-004 The module SHALL have input in_valid, 1 bit, which qualifies g for one cycle.
- REQ-005 The module SHALL have input g, WIDTH bits, the reflected-binary Gray code sample.
- REQ-006 The module SHALL have output out_valid, 1 bit, which qualifies b, dir_up and step_err.
- REQ-007 The module SHALL have output b, WIDTH bits, the registered binary equivalent of the accepted g.
- REQ-008 The module SHALL have output dir_up, 1 bit: 1 means the last good step was +1, 0 means it was -1.
- REQ-009 The module SHALL have output step_err, 1 bit, pulsed with out_valid on an illegal step.
- REQ-010 The module SHALL have output locked, 1 bit, which is high while the FSM is in LOCK.
- REQ-011 The module SHALL have output err_cnt, 8 bits, the count of illegal steps.

Function
- REQ-012 The conversion SHALL be b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1] XOR g[i] for i below WIDTH-1.
- REQ-013 Latency SHALL be 1 cycle: in_valid at edge N gives out_valid, b, dir_up and step_err valid after edge N for exactly one cycle.
- REQ-014 When in_valid=0, out_valid SHALL be 0 next cycle, step_err SHALL be 0, and b, dir_up and prev SHALL hold.
- REQ-015 The module SHALL hold a previous-sample register prev (binary, WIDTH bits), updated on every accepted sample.
- REQ-016 The step classification, computed mod 2^WIDTH, SHALL be: new-prev=+1 is UP, new-prev=-1 is DOWN, new=prev is HOLD, anything else is BAD.
- REQ-017 The classification SHALL treat wrap-around as legal: for WIDTH=4, binary 15->0 is UP and 0->15 is DOWN.
- REQ-018 The FSM SHALL have states IDLE, ACQ and LOCK, with IDLE as the reset state.
- REQ-019 In IDLE, a valid sample SHALL load prev, move to ACQ, and give step_err=0 (no reference yet).
- REQ-020 In ACQ, UP or DOWN SHALL move to LOCK; HOLD SHALL stay in ACQ; BAD SHALL stay in ACQ with step_err=1.
- REQ-021 In LOCK, UP, DOWN or HOLD SHALL stay in LOCK; BAD SHALL move to ACQ with step_err=1 and locked falling next cycle.
- REQ-022 dir_up SHALL update only on UP (set to 1) or DOWN (cleared to 0), and SHALL be unchanged on HOLD or BAD.
- REQ-023 A BAD sample SHALL still load prev and b, so that tracking resynchronises to the new position.
- REQ-024 err_cnt SHALL increment on each step_err and saturate at 255, never wrapping.

Reset
- REQ-025 Asserting rst_n=0 SHALL, immediately and independent of clk, force state=IDLE and clear out_valid, b, prev, dir_up, step_err, locked and err_cnt to 0.
- REQ-026 A reset asserted mid-stream SHALL discard history, so the first sample after release is treated as an IDLE acquisition with no step_err.
- REQ-027 Reset deassertion SHALL be followed by normal operation from the first rising clk edge at which rst_n=1.

Configuration
- REQ-028 Macro GRAY_ERR_CNT_EN SHALL control the error counter.
- REQ-029 With GRAY_ERR_CNT_EN defined, err_cnt SHALL behave per REQ-024.
- REQ-030 Without GRAY_ERR_CNT_EN, err_cnt SHALL be constant 8'd0 with no counter register, and all other behaviour SHALL be identical.

Verification (WIDTH=4)
- REQ-031 The bench SHALL drive all 16 codes, g=0000,0001,0011,...,1000 in ascending Gray order, one per cycle -> b=0..15 one cycle later, locked=1 from the 3rd out_valid, dir_up=1, no step_err.
- REQ-032 The bench SHALL drive the wrap sequence b=14,15,0,1 and then 1,0,15 in Gray -> no step_err, dir_up=1 through the wrap, then dir_up=0 after the first -1 step.
- REQ-033 The bench SHALL jump from locked at b=5 to g=1111 (b=10) -> step_err=1 for one cycle, locked=0 next cycle, err_cnt increments by 1, and the following b=11 re-locks.
- REQ-034 The bench SHALL drive a repeated sample (b=3,3,3) while in LOCK -> out_valid each cycle, no step_err, dir_up unchanged.
- REQ-035 The bench SHALL assert rst_n low between clock edges mid-stream -> all outputs are 0 immediately, and the first sample after release gives out_valid=1, step_err=0, locked=0.
- REQ-036 The bench SHALL produce 300 BAD steps -> err_cnt saturates at 255 with GRAY_ERR_CNT_EN defined and stays 0 without it.
